// File: rtl/wavefront_skew_feeder.sv
// wavefront_skew_feeder
// Feeds the transpose-conv diagonal systolic array. It takes one unskewed
// vector per iteration (Dimension weights plus one ifmap scalar) and emits a
// diagonal wavefront. At phase P, lane k carries weight[k][P-k], or 0 when
// that index lies outside the job. The job runs T = N + Dimension - 1 phases.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start            job start, honoured only in IDLE
//   num_iterations   N, latched when a start is accepted
//   in_valid/ready   source handshake for {weight_vec, ifmap_val}
//   out_valid/ready  sink handshake for {weight_out, ifmap_out, out_phase}
//   busy             high in RUN or FLUSH
//   done             one-cycle pulse at the end of a job
//
// state | meaning
// IDLE  | waiting for start
// RUN   | advancing phases 0..T-1
// FLUSH | last phase issued, waiting for it to be consumed
// DONE  | one-cycle done pulse
module wavefront_skew_feeder #(
  parameter int DW        = 16,
  parameter int Dimension = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8:0]              num_iterations,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW*Dimension-1:0] weight_vec,
  input  logic [DW-1:0]           ifmap_val,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW*Dimension-1:0] weight_out,
  output logic [DW*Dimension-1:0] ifmap_out,
  output logic [8:0]              out_phase,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [9:0] TAIL = 10'(Dimension - 1);

  state_t      state, state_nxt;
  logic [8:0]  n_lat;
  // One bit wider than out_phase so the last phase (up to N + Dimension - 2)
  // is always reachable.
  logic [9:0]  p;
  logic [9:0]  t_last;
  logic        p_lt_n;
  logic        slot_free;
  logic        advance;
  logic        out_valid_q;
  logic [8:0]  phase_q;
  logic [DW-1:0] ifmap_q;

  assign t_last = {1'b0, n_lat} + TAIL - 10'd1;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    advance   = 1'b0;
    slot_free = !out_valid_q || out_ready;
    p_lt_n    = p < {1'b0, n_lat};
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_iterations == 9'd0) ? DONE : RUN;
      end
      RUN: begin
        in_ready = p_lt_n && slot_free;
        advance  = slot_free && (!p_lt_n || in_valid);
        if (advance && (p == t_last)) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (out_valid_q && out_ready) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_lat       <= '0;
      p           <= '0;
      out_valid_q <= 1'b0;
      phase_q     <= '0;
      ifmap_q     <= '0;
    end else begin
      if (state == IDLE && start) begin
        n_lat <= num_iterations;
        p     <= '0;
      end
      if (advance) begin
        ifmap_q     <= p_lt_n ? ifmap_val : '0;
        phase_q     <= p[8:0];
        out_valid_q <= 1'b1;
        p           <= p + 10'd1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Lane k sees its injected value k advances later. Past the last input
  // zeros are injected, so the lines drain clean by the end of every job.
  for (genvar k = 0; k < Dimension; k++) begin : g_lane
    logic [DW-1:0] inj;
    logic [DW-1:0] lane_q;

    assign inj = p_lt_n ? weight_vec[k*DW +: DW] : '0;

    if (k == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (rst)          lane_q <= '0;
        else if (advance) lane_q <= inj;
      end
    end else begin : g_delay
      logic [DW-1:0] line [k];
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_q <= '0;
          for (int i = 0; i < k; i++) line[i] <= '0;
        end else if (advance) begin
          lane_q  <= line[k-1];
          line[0] <= inj;
          for (int i = 1; i < k; i++) line[i] <= line[i-1];
        end
      end
    end

    assign weight_out[k*DW +: DW] = lane_q;
  end

  assign ifmap_out = {{(DW*(Dimension-1)){1'b0}}, ifmap_q};
  assign out_valid = out_valid_q;
  assign out_phase = phase_q;
  assign busy      = (state == RUN) || (state == FLUSH);
  assign done      = (state == DONE);

endmodule
